// File: rtl/beam_scan_sequencer.sv
// Beam scan sequencer: steps a transmit beam across a fixed angular sweep.
// Each ping runs SETTLE -> BURST -> LISTEN -> REPORT. The first echo strobe
// seen in the listen window is reported together with the ping's angle.
// Handshake: result_valid_out is a one-cycle strobe with no back-pressure;
// result_angle_out, result_range_out and result_hit_out are valid in that
// cycle and hold their values until the next report.
module beam_scan_sequencer #(
  parameter int ANGLE_WIDTH   = 7,
  parameter int ANGLE_MIN     = -30,
  parameter int ANGLE_MAX     = 30,
  parameter int ANGLE_STEP    = 10,
  parameter int SETTLE_CYCLES = 16,
  parameter int BURST_CYCLES  = 524288,
  parameter int LISTEN_CYCLES = 16252928
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic                          tof_valid_in,
  input  logic [15:0]                   range_in,
  output logic signed [ANGLE_WIDTH-1:0] beam_angle_out,
  output logic                          burst_out,
  output logic                          burst_start_out,
  output logic                          listen_out,
  output logic                          result_valid_out,
  output logic signed [ANGLE_WIDTH-1:0] result_angle_out,
  output logic [15:0]                   result_range_out,
  output logic                          result_hit_out,
  output logic                          sweep_done_out,
  output logic [2:0]                    state_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    BURST  = 3'd2,
    LISTEN = 3'd3,
    REPORT = 3'd4
  } state_t;

  // Counter sized for the longest phase so it never wraps inside a state.
  localparam int MAX_A      = (SETTLE_CYCLES > BURST_CYCLES) ? SETTLE_CYCLES : BURST_CYCLES;
  localparam int MAX_CYCLES = (MAX_A > LISTEN_CYCLES) ? MAX_A : LISTEN_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'((BURST_CYCLES  > 0) ? BURST_CYCLES  - 1 : 0);
  localparam logic [CNT_W-1:0] LISTEN_LAST = CNT_W'((LISTEN_CYCLES > 0) ? LISTEN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  // Angle math carries one guard bit so the overflow test is exact.
  localparam int AW1 = ANGLE_WIDTH + 1;
  localparam logic signed [ANGLE_WIDTH:0]   MAX_G  = AW1'(ANGLE_MAX);
  localparam logic signed [ANGLE_WIDTH:0]   STEP_G = AW1'(ANGLE_STEP);
  localparam logic signed [ANGLE_WIDTH-1:0] MIN_A  = ANGLE_WIDTH'(ANGLE_MIN);

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   hit;
  logic [15:0]            range_q;
  logic signed [ANGLE_WIDTH:0] angle_g;
  logic signed [ANGLE_WIDTH:0] next_g;
  logic                   wrap;

  assign state_out = state;

  // Next sweep angle and whether this ping is the last one of the sweep.
  always_comb begin
    angle_g = {beam_angle_out[ANGLE_WIDTH-1], beam_angle_out};
    next_g  = angle_g + STEP_G;
    wrap    = (angle_g >= MAX_G) || (next_g > MAX_G);
  end

  // Ping sequencer with all outputs registered.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      cnt              <= '0;
      hit              <= 1'b0;
      range_q          <= '0;
      beam_angle_out   <= MIN_A;
      result_angle_out <= MIN_A;
      result_range_out <= '0;
      result_hit_out   <= 1'b0;
      burst_out        <= 1'b0;
      burst_start_out  <= 1'b0;
      listen_out       <= 1'b0;
      result_valid_out <= 1'b0;
      sweep_done_out   <= 1'b0;
    end else begin
      burst_start_out  <= 1'b0;
      result_valid_out <= 1'b0;
      sweep_done_out   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (enable_in) begin
            if (SETTLE_CYCLES == 0) begin
              state           <= BURST;
              burst_out       <= 1'b1;
              burst_start_out <= 1'b1;
            end else begin
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state           <= BURST;
            cnt             <= '0;
            burst_out       <= 1'b1;
            burst_start_out <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        BURST: begin
          if (cnt == BURST_LAST) begin
            state      <= LISTEN;
            cnt        <= '0;
            burst_out  <= 1'b0;
            listen_out <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        LISTEN: begin
          // Only the first strobe of the window is kept.
          if (tof_valid_in && !hit) begin
            hit     <= 1'b1;
            range_q <= range_in;
          end
          if (cnt == LISTEN_LAST) begin
            state            <= REPORT;
            cnt              <= '0;
            listen_out       <= 1'b0;
            result_valid_out <= 1'b1;
            result_angle_out <= beam_angle_out;
            result_hit_out   <= hit | tof_valid_in;
            // A strobe on the final listen cycle still counts.
            result_range_out <= hit ? range_q : (tof_valid_in ? range_in : 16'hFFFF);
            sweep_done_out   <= wrap;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        REPORT: begin
          hit            <= 1'b0;
          cnt            <= '0;
          beam_angle_out <= wrap ? MIN_A : next_g[ANGLE_WIDTH-1:0];
          if (enable_in) begin
            if (SETTLE_CYCLES == 0) begin
              state           <= BURST;
              burst_out       <= 1'b1;
              burst_start_out <= 1'b1;
            end else begin
              state <= SETTLE;
            end
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beam_scan_sequencer.sv
// Bench for beam_scan_sequencer: randomized pings against a timeline model.
module tb_beam_scan_sequencer;

  localparam int S = 2;
  localparam int B = 4;
  localparam int L = 10;
  localparam int PING_LEN = S + B + L + 1;  // posedges per ping
  localparam int A_MIN = -30;
  localparam int A_MAX = 30;
  localparam int A_STEP = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              enable;
  logic              tof_valid;
  logic [15:0]       range_v;
  logic signed [6:0] beam_angle;
  logic              burst;
  logic              burst_start;
  logic              listen;
  logic              result_valid;
  logic signed [6:0] result_angle;
  logic [15:0]       result_range;
  logic              result_hit;
  logic              sweep_done;
  logic [2:0]        state_dbg;

  beam_scan_sequencer #(
    .ANGLE_WIDTH(7), .ANGLE_MIN(A_MIN), .ANGLE_MAX(A_MAX), .ANGLE_STEP(A_STEP),
    .SETTLE_CYCLES(S), .BURST_CYCLES(B), .LISTEN_CYCLES(L)
  ) dut (
    .clk_in(clk), .rst_in(rst), .enable_in(enable),
    .tof_valid_in(tof_valid), .range_in(range_v),
    .beam_angle_out(beam_angle), .burst_out(burst), .burst_start_out(burst_start),
    .listen_out(listen), .result_valid_out(result_valid),
    .result_angle_out(result_angle), .result_range_out(result_range),
    .result_hit_out(result_hit), .sweep_done_out(sweep_done), .state_out(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] sched_q[$];  // {burst,start,listen,valid,sweep,angle} per cycle
  logic [23:0] exp_q[$];    // {angle,range,hit} per report
  int cur_angle;
  bit          tof_a[PING_LEN];
  logic [15:0] rng_a[PING_LEN];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected control outputs after posedge number o of a ping (o<0: idle).
  function automatic logic [11:0] ctl(input int o, input int ang);
    logic [6:0] a;
    logic b, st, li, v, sw;
    a  = ang[6:0];
    b  = (o >= S) && (o < S + B);
    st = (o == S);
    li = (o >= S + B) && (o < S + B + L);
    v  = (o == PING_LEN - 1);
    sw = v && (ang == A_MAX);
    return {b, st, li, v, sw, a};
  endfunction

  function automatic int next_angle(input int a);
    if (a >= A_MAX || a + A_STEP > A_MAX) return A_MIN;
    return a + A_STEP;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input bit en, input bit tv, input logic [15:0] rv, input bit r,
                      input logic [11:0] w);
    @(negedge clk);
    enable    = en;
    tof_valid = tv;
    range_v   = rv;
    rst       = r;
    sched_q.push_back(w);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)), 1'b0, ctl(-1, cur_angle));
  endtask

  task automatic clear_strobes();
    for (int o = 0; o < PING_LEN; o++) begin
      tof_a[o] = 1'b0;
      rng_a[o] = 16'h0;
    end
  endtask

  task automatic rand_strobes();
    for (int o = 0; o < PING_LEN; o++) begin
      tof_a[o] = ($urandom_range(0, 99) < 15);
      rng_a[o] = 16'($urandom_range(0, 65535));
    end
  endtask

  // One ping; drop_at/rst_at < 0 means never.
  task automatic run_ping(input int drop_at, input int rst_at);
    bit          found;
    logic [15:0] er;
    bit          en;
    found = 1'b0;
    er    = 16'hFFFF;
    for (int o = S + B + 1; o < PING_LEN; o++)
      if (tof_a[o] && !found) begin
        found = 1'b1;
        er    = rng_a[o];
      end
    for (int o = 0; o < PING_LEN; o++) begin
      if (o == rst_at) begin
        cur_angle = A_MIN;
        step(1'b1, tof_a[o], rng_a[o], 1'b1, ctl(-1, A_MIN));
        return;
      end
      en = !(drop_at >= 0 && o >= drop_at);
      if (o == PING_LEN - 1) begin
        logic [6:0] a7;
        a7 = cur_angle[6:0];
        exp_q.push_back({a7, er, found});
      end
      step(en, tof_a[o], rng_a[o], 1'b0, ctl(o, cur_angle));
    end
    cur_angle = next_angle(cur_angle);
  endtask

  // ---------------- monitor ----------------
  always begin
    logic [11:0] w;
    logic [23:0] e;
    @(posedge clk);
    #2;
    if (sched_q.size() > 0) begin
      w = sched_q.pop_front();
      check("ctl_outputs", {burst, burst_start, listen, result_valid, sweep_done, beam_angle}, w);
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_angle", 32'(result_angle[6:0]), 32'(e[23:17]));
          check("result_range", 32'(result_range), 32'(e[16:1]));
          check("result_hit", 32'(result_hit), 32'(e[0]));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; enable = 1'b0; tof_valid = 1'b0; range_v = 16'h0;
    cur_angle = A_MIN;
    repeat (3) step(1'b1, 1'b1, 16'h5555, 1'b1, ctl(-1, A_MIN));
    idle(1);
    check("reset_result_range", 32'(result_range), 32'h0);
    check("reset_result_angle", 32'(result_angle[6:0]), 32'h62);  // -30
    check("reset_result_hit", 32'(result_hit), 32'h0);
    check("reset_beam_angle", 32'(beam_angle[6:0]), 32'h62);
    idle(2);

    // single ping, echo on listen cycle 3
    clear_strobes();
    tof_a[S + B + 1 + 3] = 1'b1; rng_a[S + B + 1 + 3] = 16'h0123;
    run_ping(-1, -1);
    // full window without echo
    clear_strobes();
    run_ping(-1, -1);
    // burst strobe ignored, later listen strobes ignored
    clear_strobes();
    tof_a[S + 1] = 1'b1;          rng_a[S + 1] = 16'h0001;
    tof_a[S + B + 1 + 2] = 1'b1;  rng_a[S + B + 1 + 2] = 16'h0050;
    tof_a[S + B + 1 + 5] = 1'b1;  rng_a[S + B + 1 + 5] = 16'h0060;
    run_ping(-1, -1);
    // strobes in REPORT and last BURST cycle ignored, last LISTEN cycle counts
    clear_strobes();
    tof_a[0] = 1'b1;            rng_a[0] = 16'h1111;
    tof_a[S + B] = 1'b1;        rng_a[S + B] = 16'h2222;
    tof_a[PING_LEN - 1] = 1'b1; rng_a[PING_LEN - 1] = 16'hBEEF;
    run_ping(-1, -1);
    // rest of the sweep and the wrap back to the first angle
    for (int k = 0; k < 4; k++) begin
      rand_strobes();
      run_ping(-1, -1);
    end
    // enable dropped mid-listen: ping completes, then idle at next angle
    rand_strobes();
    run_ping(S + B + 4, -1);
    idle(4);
    // reset in the middle of a burst: ping discarded
    rand_strobes();
    run_ping(-1, S + 2);
    idle(4);
    // restart from the first angle, enable dropped on the final listen cycle
    rand_strobes();
    run_ping(PING_LEN - 1, -1);
    idle(3);

    @(posedge clk);
    #4;
    check("sched_drained", 32'(sched_q.size()), 32'd0);
    check("results_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/beam_scan_sequencer.md
BEAM_SCAN_SEQUENCER -- requirements
Module: beam_scan_sequencer

Interface
REQ-001 The block SHALL have a single clock; reset is synchronous and active-high.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- ANGLE_WIDTH, 7, signed beam-angle width in degrees.
- ANGLE_MIN, -30, first angle of the sweep.
- ANGLE_MAX, 30, last angle of the sweep.
- ANGLE_STEP, 10, angle increment per ping.
- SETTLE_CYCLES, 16, dwell after an angle change before the burst.
- BURST_CYCLES, 524288, transmit burst length.
- LISTEN_CYCLES, 16252928, echo window length after the burst.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk_in, in, 1, system clock (100 MHz).
- rst_in, in, 1, synchronous active-high reset.
- enable_in, in, 1, level; scanning runs while high.
- tof_valid_in, in, 1, time-of-flight echo result strobe.
- range_in, in, 16, range accompanying tof_valid_in.
- beam_angle_out, out, ANGLE_WIDTH signed, angle applied to the sine LUT and beamformers.
- burst_out, out, 1, high for the whole transmit burst (gates the transmitters).
- burst_start_out, out, 1, one-cycle pulse on the first burst cycle (resets the TOF, SPI and counters).
- listen_out, out, 1, high during the echo window.
- result_valid_out, out, 1, one-cycle pulse per completed ping.
- result_angle_out, out, ANGLE_WIDTH signed, angle of the reported ping.
- result_range_out, out, 16, reported range.
- result_hit_out, out, 1, an echo was captured in the window.
- sweep_done_out, out, 1, one-cycle pulse when the ANGLE_MAX ping is reported.

Function
REQ-004 The block SHALL implement the states IDLE, SETTLE, BURST, LISTEN and REPORT.
REQ-005 IDLE: when enable_in=1, the block SHALL enter SETTLE on the next cycle.
REQ-006 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to BURST; SETTLE_CYCLES=0 SHALL skip straight to BURST.
REQ-007 BURST SHALL last exactly BURST_CYCLES cycles, with burst_out=1 on each of them and burst_start_out=1 only on the first.
REQ-008 After BURST the block SHALL go to LISTEN, which lasts exactly LISTEN_CYCLES cycles with listen_out=1.
REQ-009 REPORT SHALL last exactly 1 cycle, with result_valid_out=1 and result outputs driven.
REQ-010 In LISTEN, the first cycle with tof_valid_in=1 SHALL latch range_in and set the hit flag.
- Later strobes in the same window SHALL be ignored.
- Strobes in IDLE, SETTLE, BURST or REPORT SHALL be ignored.
- A strobe on the last LISTEN cycle SHALL count.
REQ-011 REPORT outputs SHALL be as follows:
- result_range_out = latched range on a hit, else 16'hFFFF.
- result_hit_out = hit flag.
- result_angle_out = beam_angle_out of that ping.
REQ-012 On leaving REPORT, the hit flag SHALL clear and beam_angle_out SHALL advance by ANGLE_STEP.
- If the current angle is >= ANGLE_MAX, or the next angle would exceed ANGLE_MAX, beam_angle_out SHALL wrap to ANGLE_MIN.
- sweep_done_out SHALL pulse in that REPORT cycle.
REQ-013 beam_angle_out SHALL change only on REPORT exit or reset, and SHALL be stable throughout SETTLE, BURST and LISTEN.
REQ-014 After REPORT, the block SHALL enter SETTLE if enable_in=1, else IDLE.
- enable_in deasserted mid-ping SHALL NOT abort the ping; the current ping SHALL complete through REPORT.
REQ-015 Counters SHALL be wide enough for the largest of SETTLE_CYCLES, BURST_CYCLES and LISTEN_CYCLES.
- Counters SHALL never wrap within a state.
- Angle arithmetic SHALL be signed with one guard bit, so the overflow check is exact.
REQ-016 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-017 Reset SHALL put the block in IDLE with these output values:
- beam_angle_out=ANGLE_MIN, result_angle_out=ANGLE_MIN.
- result_range_out=0, result_hit_out=0.
- burst_out, burst_start_out, listen_out, result_valid_out and sweep_done_out all 0.
- Counters and the hit flag cleared.
REQ-018 Reset asserted in any state, including mid-BURST, SHALL drop burst_out on the next cycle and discard the ping in progress, with no REPORT issued.

Verification (SETTLE_CYCLES=2, BURST_CYCLES=4, LISTEN_CYCLES=10, other parameters at default)
REQ-019 Single ping: enable_in rises at cycle 0 and tof_valid_in pulses with range_in=0x0123 at LISTEN cycle 3 -> the bench SHALL observe:
- burst_out high for 4 cycles, burst_start_out a single pulse, listen_out high for 10 cycles;
- then result_valid_out with range 0x0123, hit=1, angle=-30.
REQ-020 No echo: a full window with no strobe -> result_range_out=0xFFFF and result_hit_out=0.
REQ-021 Multiple strobes: strobes at BURST cycle 1 (range 0x0001), LISTEN cycle 2 (0x0050) and LISTEN cycle 5 (0x0060) -> the reported range SHALL be 0x0050.
REQ-022 Full sweep with enable_in held high:
- reported angles SHALL be -30, -20, -10, 0, 10, 20, 30, then -30;
- sweep_done_out SHALL pulse only on the angle-30 REPORT.
REQ-023 Disable mid-ping: enable_in dropped during LISTEN -> that ping SHALL still report, then the block SHALL return to IDLE with beam_angle_out advanced by 10.
REQ-024 Reset mid-operation: rst_in pulsed at BURST cycle 2 -> burst_out=0 on the next cycle, no result_valid_out, beam_angle_out=-30.
